// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> memory 128-bit line interface.
package mem_if_pkg;

  localparam int unsigned LINE_W     = 128;
  localparam int unsigned MEM_ADDR_W = 28;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/line_ram.sv
// Line storage: 2^DEPTH_LOG2 x 128-bit array, synchronous write, registered read port.
module line_ram
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [LINE_W-1:0]     i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [LINE_W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [LINE_W-1:0] r_rdata;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register holds its value between read strobes.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset)  r_rdata <= '0;
    else if (i_re)   r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the cache line interface: one request at a time,
// single-cycle ready pulse after LATENCY cycles, sticky protocol error flag.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  protocol_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_addr_q, w_addr_nxt;
  op_t                   r_op_q, w_op_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_err, w_err_nxt;

  logic                  w_req;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [DEPTH_LOG2-1:0] w_ram_raddr;
  logic [LINE_W-1:0]     w_ram_rdata;
  logic                  w_unused_addr;

  assign w_req         = mem_read | mem_write;
  assign w_idx         = mem_addr[DEPTH_LOG2-1:0];
  // Upper address bits alias onto the same lines.
  assign w_unused_addr = ^mem_addr[MEM_ADDR_W-1:DEPTH_LOG2];

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr_q <= '0;
      r_op_q   <= OP_RD;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr_q <= w_addr_nxt;
      r_op_q   <= w_op_nxt;
      r_ready  <= w_ready_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr_q;
    w_op_nxt    = r_op_q;
    w_ready_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_raddr = r_addr_q;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_addr_nxt = w_idx;
          w_op_nxt   = mem_write ? OP_WR : OP_RD;
          w_cnt_nxt  = CNT_LOAD;
          if (mem_read && mem_write) w_err_nxt = 1'b1;
          if (CNT_LOAD != '0) begin
            w_state_nxt = BUSY;
          end else begin
            // Single-cycle latency: read data must be captured on the accept edge.
            w_state_nxt = RESP;
            w_ready_nxt = 1'b1;
            if (!mem_write) begin
              w_ram_re    = 1'b1;
              w_ram_raddr = w_idx;
            end
          end
        end
      end

      BUSY: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else begin
          if (w_idx != r_addr_q) w_err_nxt = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = RESP;
            w_ready_nxt = 1'b1;
            if (r_op_q == OP_RD) w_ram_re = 1'b1;
          end
        end
      end

      // Write data trails the address by a cycle, so commit at the end of RESP.
      RESP: begin
        if (r_op_q == OP_WR) w_ram_we = 1'b1;
        w_state_nxt = RECOVER;
      end

      RECOVER: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  line_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_line_ram (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_we       (w_ram_we),
    .i_waddr    (r_addr_q),
    .i_wdata    (mem_wdata),
    .i_re       (w_ram_re),
    .i_raddr    (w_ram_raddr),
    .o_rdata    (w_ram_rdata)
  );

  assign mem_rdata    = w_ram_rdata;
  assign mem_ready    = r_ready;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: LATENCY=5 and LATENCY=1 instances, scoreboard of expected responses.
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset;
  logic         a_rd, a_wr, a_ready, a_err;
  logic [27:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic         b_rd, b_wr, b_ready, b_err;
  logic [27:0]  b_addr;
  logic [127:0] b_wdata, b_rdata;

  line_mem_responder #(.LATENCY(5), .DEPTH_LOG2(8)) dut_a (
    .clk(clk), .proc_reset(proc_reset), .mem_read(a_rd), .mem_write(a_wr),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
    .mem_ready(a_ready), .protocol_err(a_err)
  );

  line_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut_b (
    .clk(clk), .proc_reset(proc_reset), .mem_read(b_rd), .mem_write(b_wr),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
    .mem_ready(b_ready), .protocol_err(b_err)
  );

  typedef struct {
    logic [127:0] data;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  localparam logic [127:0] D_DEAD = 128'hDEAD0000_11112222_33334444_5555BEEF;
  localparam logic [127:0] D_ONES = {32{4'h1}};
  localparam logic [127:0] D_TWOS = {32{4'h2}};
  localparam logic [127:0] D_A    = 128'hA5A5A5A5_00000000_FFFFFFFF_0123ABCD;
  localparam logic [127:0] D_B    = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] D_X    = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [127:0] D_V    = 128'hCAFEF00D_00C0FFEE_FEEDFACE_BAADC0DE;

  // Cache-like transaction on dut_a; wdata is driven one cycle after the address.
  task automatic txn_a(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data, input bit drop_early,
                       output int lat, output logic [127:0] rdv, output logic extra);
    bit got;
    got = 0; lat = 0; rdv = '0; extra = 1'b0;
    a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = ~data;
    @(posedge clk); #1;
    a_wdata = data;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (a_ready) begin got = 1; lat = i; rdv = a_rdata; break; end
    end
    if (got) begin
      @(posedge clk); #1;
      if (drop_early) begin a_rd = 0; a_wr = 0; end
      @(negedge clk);
      extra = a_ready;
    end
    @(posedge clk); #1;
    a_rd = 0; a_wr = 0;
  endtask

  task automatic test_reset;
    proc_reset = 1'b1;
    a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b exp=0/0", a_ready, b_ready); end
    total++; if (a_rdata !== '0 || b_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", a_rdata); end
    total++; if (a_err !== 1'b0 || b_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0/0", a_err, b_err); end
    proc_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    exp_t e; int lat; logic [127:0] rdv; logic extra;
    sb.push_back('{data: '0, lat: 5});
    txn_a(1'b0, 1'b1, 28'h0000003, D_DEAD, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL wr3_latency got=%0d exp=%0d", lat, e.lat); end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL wr3_recover_pulse got=%b exp=0", extra); end
    sb.push_back('{data: D_DEAD, lat: 5});
    txn_a(1'b1, 1'b0, 28'h0000003, D_DEAD, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL rd3_latency got=%0d exp=%0d", lat, e.lat); end
    total++; if (rdv !== e.data) begin bad++; $display("FAIL rd3_data got=%h exp=%h", rdv, e.data); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rd3_err got=%b exp=0", a_err); end
    sb.push_back('{data: '0, lat: 5});
    txn_a(1'b0, 1'b1, 28'h0000007, D_ONES, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL wr7_latency got=%0d exp=%0d", lat, e.lat); end
  endtask

  task automatic test_alias;
    exp_t e; int lat; logic [127:0] rdv; logic extra;
    txn_a(1'b0, 1'b1, 28'h0000105, D_A, 1'b0, lat, rdv, extra);
    sb.push_back('{data: D_A, lat: 5});
    txn_a(1'b1, 1'b0, 28'h0000005, D_A, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (rdv !== e.data || lat !== e.lat) begin bad++; $display("FAIL alias_rd got=%h/%0d exp=%h/%0d", rdv, lat, e.data, e.lat); end
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat; logic [127:0] rdv; logic extra;
    sb.push_back('{data: '0, lat: 5});
    txn_a(1'b0, 1'b1, 28'h0000040, D_B, 1'b1, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (lat !== e.lat || extra !== 1'b0) begin bad++; $display("FAIL b2b_wr got=%0d/%b exp=%0d/0", lat, extra, e.lat); end
    sb.push_back('{data: D_B, lat: 5});
    txn_a(1'b1, 1'b0, 28'h0000040, D_B, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL b2b_rd_latency got=%0d exp=%0d", lat, e.lat); end
    total++; if (rdv !== e.data) begin bad++; $display("FAIL b2b_rd_data got=%h exp=%h", rdv, e.data); end
    sb.push_back('{data: D_DEAD, lat: 5});
    txn_a(1'b1, 1'b0, 28'h0000003, D_DEAD, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (rdv !== e.data) begin bad++; $display("FAIL b2b_rd3_data got=%h exp=%h", rdv, e.data); end
  endtask

  task automatic test_latency1;
    exp_t e;
    b_wr = 1; b_addr = 28'h0000009; b_wdata = D_V;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL l1_wr_ready got=%b exp=1", b_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_wr_recover got=%b exp=0", b_ready); end
    @(posedge clk); #1;
    b_wr = 0; b_wdata = '0;
    sb.push_back('{data: D_V, lat: 1});
    b_rd = 1;
    @(negedge clk);
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_rd_early got=%b exp=0", b_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    e = sb.pop_front();
    total++; if (b_ready !== 1'b1 || b_rdata !== e.data) begin bad++; $display("FAIL l1_rd got=%b/%h exp=1/%h", b_ready, b_rdata, e.data); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_rd_recover got=%b exp=0", b_ready); end
    @(posedge clk); #1;
    b_rd = 0;
    @(negedge clk);
    total++; if (b_ready !== 1'b0 || b_err !== 1'b0) begin bad++; $display("FAIL l1_idle got=%b/%b exp=0/0", b_ready, b_err); end
  endtask

  task automatic test_both_high;
    exp_t e; int lat; logic [127:0] rdv; logic extra;
    sb.push_back('{data: '0, lat: 5});
    txn_a(1'b1, 1'b1, 28'h0000050, D_X, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL both_latency got=%0d exp=%0d", lat, e.lat); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL both_err got=%b exp=1", a_err); end
    sb.push_back('{data: D_X, lat: 5});
    txn_a(1'b1, 1'b0, 28'h0000050, D_X, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (rdv !== e.data) begin bad++; $display("FAIL both_written got=%h exp=%h", rdv, e.data); end
  endtask

  task automatic test_reset_mid_write;
    exp_t e; int lat; int pulses; logic [127:0] rdv; logic extra;
    a_wr = 1; a_addr = 28'h0000007; a_wdata = D_TWOS;
    @(posedge clk); #1;
    @(posedge clk); #1;
    proc_reset = 1'b1;
    #1;
    total++; if (a_ready !== 1'b0 || a_rdata !== '0 || a_err !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs got=%b/%h/%b exp=0/0/0", a_ready, a_rdata, a_err); end
    @(posedge clk); #1;
    proc_reset = 1'b0; a_wr = 0;
    pulses = 0;
    repeat (10) begin @(negedge clk); if (a_ready) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulses); end
    @(posedge clk); #1;
    sb.push_back('{data: D_ONES, lat: 5});
    txn_a(1'b1, 1'b0, 28'h0000007, D_ONES, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (rdv !== e.data || lat !== e.lat) begin bad++; $display("FAIL rst_mid_rd7 got=%h/%0d exp=%h/%0d", rdv, lat, e.data, e.lat); end
  endtask

  task automatic test_addr_change;
    exp_t e; int lat; logic [127:0] rdv; logic extra;
    sb.push_back('{data: '0, lat: 5});
    lat = 0;
    a_wr = 1; a_addr = 28'h0000020; a_wdata = D_V;
    @(posedge clk); #1;
    a_addr = 28'h0000021;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (a_ready) begin lat = i; break; end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_wr = 0;
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL addrchg_latency got=%0d exp=%0d", lat, e.lat); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL addrchg_err got=%b exp=1", a_err); end
    sb.push_back('{data: D_V, lat: 5});
    txn_a(1'b1, 1'b0, 28'h0000020, D_V, 1'b0, lat, rdv, extra);
    e = sb.pop_front();
    total++; if (rdv !== e.data) begin bad++; $display("FAIL addrchg_rd got=%h exp=%h", rdv, e.data); end
  endtask

  task automatic test_abort;
    int pulses;
    proc_reset = 1'b1;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    a_rd = 1; a_addr = 28'h0000003;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_rd = 0;
    pulses = 0;
    repeat (10) begin @(negedge clk); if (a_ready) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL abort_err got=%b exp=1", a_err); end
    repeat (5) @(negedge clk);
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL abort_err_sticky got=%b exp=1", a_err); end
    @(posedge clk); #1;
    proc_reset = 1'b1;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    @(negedge clk);
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL abort_err_cleared got=%b exp=0", a_err); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_latency1();
    test_both_high();
    test_reset_mid_write();
    test_addr_change();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Memory-side responder for the cache's 128-bit line interface; it acts as the target of `mem_read`/`mem_write` requests from the cache controller. It holds a line-addressed storage array, accepts one request at a time, and returns a single-cycle `mem_ready` pulse after a fixed programmable latency. It serves as the main-memory model in the CPU+cache simulation top level and as a synthesizable on-chip backing store.

## Interface
- `LATENCY`, default 5: cycles from request acceptance to `mem_ready`; legal range 1..255.
- `DEPTH_LOG2`, default 8: storage holds 2^DEPTH_LOG2 lines of 128 bits.
- `clk` input 1: clock, rising edge.
- `proc_reset` input 1: reset, asynchronous, active-high.
- `mem_read` input 1: line read request, level, held until the ready pulse has been seen.
- `mem_write` input 1: line write request, same rules as `mem_read`.
- `mem_addr` input 28: line address; index = `mem_addr[DEPTH_LOG2-1:0]`, upper bits ignored (aliasing).
- `mem_wdata` input 128: write line data.
- `mem_rdata` output 128: read line data, registered.
- `mem_ready` output 1: one-cycle completion pulse.
- `protocol_err` output 1: sticky violation flag, cleared only by reset.

## Operation
- FSM states: IDLE, BUSY, RESP, RECOVER.
- IDLE: if `mem_read|mem_write`, accept: latch index into `addr_q`, latch op into `op_q` (write wins if both high, and set `protocol_err`), load `cnt = LATENCY-1`. Next state BUSY if `cnt>0`, else RESP.
- BUSY: decrement `cnt`. On the transition to RESP (`cnt==1`), for a read: `mem_rdata <= array[addr_q]`.
  - LATENCY==1 read: load `mem_rdata` on the accept edge.
- BUSY, request dropped (both low): abort to IDLE. No ready pulse, no array write, set `protocol_err`.
- BUSY, `mem_addr` index differs from `addr_q`: set `protocol_err`; the transaction continues on `addr_q`.
- RESP: `mem_ready=1` for exactly one cycle. For a write, `array[addr_q] <= mem_wdata`, sampled at the edge ending RESP, not at acceptance, because the cache's `mem_wdata` lags its address by one register. Next state RECOVER.
- RECOVER: ignore requests for one cycle, because the cache keeps its request high during the cycle after the pulse. Next state IDLE.
- `mem_rdata` holds its last value outside RESP. Writes never modify `mem_rdata`.
- Storage is not reset. Contents are undefined until written.

## Timing
- Reset values: `mem_ready=0`, `mem_rdata=0`, `protocol_err=0`, state IDLE, `cnt=0`.
- Request first high in IDLE at cycle c → `mem_ready` high in cycle c+LATENCY → RECOVER at c+LATENCY+1 → earliest next accept at c+LATENCY+2.
- Read data is valid during the `mem_ready` cycle, which the cache's registered capture requires.
- Back-to-back writeback then allocate: the cache drops `mem_write` in the cycle after ready and raises `mem_read` one cycle later. That read is accepted in IDLE with no lost cycle.
- Reset mid-transaction: immediate return to IDLE, outputs to reset values, no array write, no ready pulse.
- `cnt` is 8 bits wide.

## Structure
- Shared package `mem_if_pkg`:
  - `LINE_W=128`, `MEM_ADDR_W=28`.
  - FSM state enum (2-bit: IDLE=0, BUSY=1, RESP=2, RECOVER=3).
  - Op encoding (`OP_RD=0`, `OP_WR=1`).
- Sub-module `line_ram`: 2^DEPTH_LOG2 × 128 array, synchronous write, synchronous registered read port. `line_mem_responder` contains the FSM, counter and error logic.

## Test plan
- Write then read, LATENCY=5: write addr 0x0000003 data 0xDEAD…BEEF; ready at cycle c+5. Read 0x0000003 → ready at c'+5 with `mem_rdata`=0xDEAD…BEEF; `protocol_err`=0.
- LATENCY=1: read accepted at cycle c → ready and valid data at c+1. Request held through c+2 (RECOVER) → no second ready pulse.
- Writeback+allocate sequence driven by the real cache: dirty miss on set 2 → old line lands at the {old tag, 2} index, new line returns. CPU read returns the preloaded word.
- Aliasing, DEPTH_LOG2=8: write 0x0000105 = A; read 0x0000005 → A.
- Violations: `mem_read` and `mem_write` both high → write performed, `protocol_err`=1. Request dropped in BUSY → no ready pulse; `protocol_err` stays 1 until reset.
- `proc_reset` pulsed in BUSY of a write to 0x7 (previously 0x11…1) → `mem_ready` never pulses; after reset, read 0x7 returns 0x11…1.
